// File: rtl/ahblsram_ahb_slave_if.sv
// AHB-Lite slave front end for the embedded SRAM: decodes bus transfers, issues
// one-cycle SRAM requests, inserts wait states and reports range/alignment errors.
module ahblsram_ahb_slave_if #(
    parameter int AHB_DWIDTH     = 32,
    parameter int MEM_SIZE_BYTES = 2048
) (
    input  logic                  HCLK,
    input  logic                  aresetn,
    input  logic                  HSEL,
    input  logic [19:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [AHB_DWIDTH-1:0] HWDATA,
    input  logic                  HREADYIN,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [AHB_DWIDTH-1:0] HRDATA,
    output logic                  ahbsram_req,
    output logic                  ahbsram_write,
    output logic [2:0]            ahbsram_size,
    output logic [19:0]           ahbsram_addr,
    output logic [AHB_DWIDTH-1:0] ahbsram_wdata,
    input  logic                  sramahb_ack,
    input  logic [AHB_DWIDTH-1:0] sramahb_rdata,
    input  logic                  BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BWAIT,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [31:0] MEM_LIMIT = MEM_SIZE_BYTES;

    state_t                  state;
    state_t                  state_nxt;
    logic                    accept;
    logic                    valid;
    logic                    range_err;
    logic                    align_err;
    logic                    size_err;
    logic                    xfer_err;
    logic [31:0]             haddr_ext;
    logic                    write_r;
    logic [2:0]              size_r;
    logic [19:0]             addr_r;
    logic [AHB_DWIDTH-1:0]   rdata_r;
    logic                    unused_inputs;

    // Bursts are handled beat by beat; only HTRANS[1] distinguishes NONSEQ/SEQ.
    assign unused_inputs = ^{HBURST, HTRANS[0]};

    assign haddr_ext = {12'b0, HADDR};

    always_comb begin
        accept    = (state == S_IDLE) || (state == S_RESP) || (state == S_ERR2);
        valid     = HSEL & HREADYIN & HTRANS[1] & accept;
        range_err = (haddr_ext >= MEM_LIMIT);
        size_err  = (HSIZE > 3'b010);
        align_err = ((HSIZE == 3'b001) && HADDR[0]) ||
                    ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
        xfer_err  = range_err | size_err | align_err;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_RESP, S_ERR2: begin
                if (!valid)        state_nxt = S_IDLE;
                else if (xfer_err) state_nxt = S_ERR1;
                else if (BUSY)     state_nxt = S_BWAIT;
                else               state_nxt = S_REQ;
            end
            S_BWAIT: if (!BUSY) state_nxt = S_REQ;
            S_REQ:   state_nxt = S_WAIT;
            // BUSY is deliberately ignored here: an issued request always completes.
            S_WAIT:  if (sramahb_ack) state_nxt = S_RESP;
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            state   <= S_IDLE;
            write_r <= 1'b0;
            size_r  <= '0;
            addr_r  <= '0;
            rdata_r <= '0;
        end else begin
            state <= state_nxt;
            if (valid) begin
                write_r <= HWRITE;
                size_r  <= HSIZE;
                addr_r  <= HADDR;
            end
            if ((state == S_RESP) && !write_r)
                rdata_r <= sramahb_rdata;
        end
    end

    always_comb begin
        HREADYOUT     = accept;
        HRESP         = (state == S_ERR1) || (state == S_ERR2);
        ahbsram_req   = (state == S_REQ);
        ahbsram_write = write_r;
        ahbsram_size  = size_r;
        ahbsram_addr  = addr_r;
        ahbsram_wdata = (state == S_REQ) ? HWDATA : '0;
        // Read data arrives in RESP itself, so it is muxed through live and then held.
        HRDATA        = ((state == S_RESP) && !write_r) ? sramahb_rdata : rdata_r;
    end

endmodule

// File: tb/tb_ahblsram_ahb_slave_if.sv
// Directed bench for ahblsram_ahb_slave_if: a vector table of single transfers
// plus hand-written back-to-back, BUSY and mid-transfer reset sequences.
module tb_ahblsram_ahb_slave_if;

    logic        HCLK = 1'b0;
    logic        aresetn;
    logic        HSEL;
    logic [19:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        ahbsram_req;
    logic        ahbsram_write;
    logic [2:0]  ahbsram_size;
    logic [19:0] ahbsram_addr;
    logic [31:0] ahbsram_wdata;
    logic        sramahb_ack;
    logic [31:0] sramahb_rdata;
    logic        BUSY;

    int total = 0;
    int bad   = 0;
    logic [19:0] last_addr;
    logic [31:0] last_rdata;

    localparam int K_OK  = 0;
    localparam int K_ERR = 1;
    localparam int K_IGN = 2;

    typedef struct {
        logic        hsel;
        logic [1:0]  htrans;
        logic        hreadyin;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [19:0] haddr;
        logic [31:0] hwdata;
        logic [31:0] rdata;
        int          ack_dly;
        int          kind;
    } vec_t;

    vec_t vecs [15];

    ahblsram_ahb_slave_if #(
        .AHB_DWIDTH     (32),
        .MEM_SIZE_BYTES (2048)
    ) dut (
        .HCLK          (HCLK),
        .aresetn       (aresetn),
        .HSEL          (HSEL),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HWRITE        (HWRITE),
        .HSIZE         (HSIZE),
        .HBURST        (HBURST),
        .HWDATA        (HWDATA),
        .HREADYIN      (HREADYIN),
        .HREADYOUT     (HREADYOUT),
        .HRESP         (HRESP),
        .HRDATA        (HRDATA),
        .ahbsram_req   (ahbsram_req),
        .ahbsram_write (ahbsram_write),
        .ahbsram_size  (ahbsram_size),
        .ahbsram_addr  (ahbsram_addr),
        .ahbsram_wdata (ahbsram_wdata),
        .sramahb_ack   (sramahb_ack),
        .sramahb_rdata (sramahb_rdata),
        .BUSY          (BUSY)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle;
        HSEL     = 1'b0;
        HTRANS   = 2'b00;
        HREADYIN = 1'b1;
    endtask

    task automatic addr_phase(input logic w, input logic [2:0] sz, input logic [19:0] a);
        HSEL     = 1'b1;
        HTRANS   = 2'b10;
        HREADYIN = 1'b1;
        HWRITE   = w;
        HSIZE    = sz;
        HADDR    = a;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        HSEL     = v.hsel;
        HTRANS   = v.htrans;
        HREADYIN = v.hreadyin;
        HWRITE   = v.hwrite;
        HSIZE    = v.hsize;
        HADDR    = v.haddr;
        sramahb_rdata = 32'h0BAD0BAD;
        tick;
        bus_idle;
        HWDATA = v.hwdata;
        #1;
        case (v.kind)
            K_IGN: begin
                chk1({tag, "_ign_ready"}, HREADYOUT, 1'b1);
                chk1({tag, "_ign_resp"}, HRESP, 1'b0);
                chk1({tag, "_ign_req"}, ahbsram_req, 1'b0);
                chk({tag, "_ign_addr"}, 32'(ahbsram_addr), 32'(last_addr));
                tick;
                chk1({tag, "_ign_ready2"}, HREADYOUT, 1'b1);
            end
            K_ERR: begin
                last_addr = v.haddr;
                chk1({tag, "_err1_ready"}, HREADYOUT, 1'b0);
                chk1({tag, "_err1_resp"}, HRESP, 1'b1);
                chk1({tag, "_err1_req"}, ahbsram_req, 1'b0);
                tick;
                chk1({tag, "_err2_ready"}, HREADYOUT, 1'b1);
                chk1({tag, "_err2_resp"}, HRESP, 1'b1);
                chk1({tag, "_err2_req"}, ahbsram_req, 1'b0);
                tick;
                chk1({tag, "_post_ready"}, HREADYOUT, 1'b1);
                chk1({tag, "_post_resp"}, HRESP, 1'b0);
                chk({tag, "_post_addr"}, 32'(ahbsram_addr), 32'(last_addr));
                chk({tag, "_post_hrdata"}, HRDATA, last_rdata);
            end
            default: begin
                last_addr = v.haddr;
                chk1({tag, "_c1_req"}, ahbsram_req, 1'b1);
                chk1({tag, "_c1_ready"}, HREADYOUT, 1'b0);
                chk1({tag, "_c1_write"}, ahbsram_write, v.hwrite);
                chk({tag, "_c1_size"}, 32'(ahbsram_size), 32'(v.hsize));
                chk({tag, "_c1_addr"}, 32'(ahbsram_addr), 32'(v.haddr));
                chk({tag, "_c1_wdata"}, ahbsram_wdata, v.hwdata);
                tick;
                for (int k = 0; k <= v.ack_dly; k++) begin
                    chk1({tag, "_wait_ready"}, HREADYOUT, 1'b0);
                    chk1({tag, "_wait_req"}, ahbsram_req, 1'b0);
                    chk({tag, "_wait_wdata"}, ahbsram_wdata, 32'h0);
                    chk({tag, "_wait_addr"}, 32'(ahbsram_addr), 32'(v.haddr));
                    sramahb_ack = (k == v.ack_dly);
                    tick;
                end
                sramahb_ack   = 1'b0;
                sramahb_rdata = v.rdata;
                #1;
                chk1({tag, "_resp_ready"}, HREADYOUT, 1'b1);
                chk1({tag, "_resp_resp"}, HRESP, 1'b0);
                chk1({tag, "_resp_req"}, ahbsram_req, 1'b0);
                if (!v.hwrite) last_rdata = v.rdata;
                chk({tag, "_resp_hrdata"}, HRDATA, last_rdata);
                tick;
                sramahb_rdata = ~v.rdata;
                #1;
                chk1({tag, "_idle_ready"}, HREADYOUT, 1'b1);
                chk({tag, "_hold_hrdata"}, HRDATA, last_rdata);
            end
        endcase
    endtask

    initial begin
        aresetn = 1'b0;
        bus_idle;
        HWRITE = 1'b0;
        HSIZE  = 3'b000;
        HADDR  = 20'h0;
        HBURST = 3'b000;
        HWDATA = 32'h0;
        sramahb_ack   = 1'b0;
        sramahb_rdata = 32'h0BAD0BAD;
        BUSY       = 1'b0;
        last_addr  = 20'h0;
        last_rdata = 32'h0;

        //          hsel  htrans hrdyin hwrite hsize   haddr      hwdata        rdata        dly kind
        vecs[0]  = '{1'b1, 2'b10, 1'b1, 1'b1, 3'b010, 20'h00010, 32'hDEADBEEF, 32'h0,        0, K_OK};
        vecs[1]  = '{1'b1, 2'b10, 1'b1, 1'b0, 3'b010, 20'h00010, 32'h0,        32'hDEADBEEF, 0, K_OK};
        vecs[2]  = '{1'b1, 2'b10, 1'b1, 1'b1, 3'b001, 20'h00002, 32'h0000BEEF, 32'h0,        2, K_OK};
        vecs[3]  = '{1'b1, 2'b10, 1'b1, 1'b0, 3'b000, 20'h007FF, 32'h0,        32'h000000A5, 1, K_OK};
        vecs[4]  = '{1'b1, 2'b11, 1'b1, 1'b0, 3'b010, 20'h007FC, 32'h0,        32'h12345678, 0, K_OK};
        vecs[5]  = '{1'b1, 2'b10, 1'b1, 1'b0, 3'b010, 20'h00002, 32'h0,        32'h0,        0, K_ERR};
        vecs[6]  = '{1'b1, 2'b10, 1'b1, 1'b0, 3'b010, 20'h00800, 32'h0,        32'h0,        0, K_ERR};
        vecs[7]  = '{1'b1, 2'b10, 1'b1, 1'b1, 3'b001, 20'h00001, 32'h0,        32'h0,        0, K_ERR};
        vecs[8]  = '{1'b1, 2'b10, 1'b1, 1'b0, 3'b011, 20'h00000, 32'h0,        32'h0,        0, K_ERR};
        vecs[9]  = '{1'b1, 2'b10, 1'b1, 1'b1, 3'b000, 20'hFFFFF, 32'h0,        32'h0,        0, K_ERR};
        vecs[10] = '{1'b1, 2'b00, 1'b1, 1'b1, 3'b010, 20'h00040, 32'h0,        32'h0,        0, K_IGN};
        vecs[11] = '{1'b1, 2'b01, 1'b1, 1'b1, 3'b010, 20'h00044, 32'h0,        32'h0,        0, K_IGN};
        vecs[12] = '{1'b0, 2'b10, 1'b1, 1'b1, 3'b010, 20'h00048, 32'h0,        32'h0,        0, K_IGN};
        vecs[13] = '{1'b1, 2'b10, 1'b0, 1'b1, 3'b010, 20'h0004C, 32'h0,        32'h0,        0, K_IGN};
        vecs[14] = '{1'b1, 2'b10, 1'b1, 1'b1, 3'b010, 20'h00004, 32'hA5A5F00F, 32'h0,        1, K_OK};

        // Reset values
        tick;
        tick;
        chk1("rst_ready", HREADYOUT, 1'b1);
        chk1("rst_resp", HRESP, 1'b0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk1("rst_req", ahbsram_req, 1'b0);
        chk1("rst_write", ahbsram_write, 1'b0);
        chk("rst_size", 32'(ahbsram_size), 32'h0);
        chk("rst_addr", 32'(ahbsram_addr), 32'h0);
        chk("rst_wdata", ahbsram_wdata, 32'h0);
        @(negedge HCLK);
        aresetn = 1'b1;
        tick;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Back-to-back: byte write sampled in the RESP cycle of a word write
        addr_phase(1'b1, 3'b010, 20'h00010);
        tick;
        bus_idle;
        HWDATA = 32'h11112222;
        #1;
        chk1("b2b_c1_req", ahbsram_req, 1'b1);
        tick;
        sramahb_ack = 1'b1;
        tick;
        sramahb_ack = 1'b0;
        chk1("b2b_resp_ready", HREADYOUT, 1'b1);
        addr_phase(1'b1, 3'b000, 20'h00013);
        tick;
        bus_idle;
        HWDATA = 32'h000000CC;
        #1;
        chk1("b2b_req2", ahbsram_req, 1'b1);
        chk1("b2b_ready2", HREADYOUT, 1'b0);
        chk("b2b_size2", 32'(ahbsram_size), 32'h0);
        chk("b2b_addr2", 32'(ahbsram_addr), 32'h00013);
        chk("b2b_wdata2", ahbsram_wdata, 32'h000000CC);
        tick;
        chk1("b2b_wait_req", ahbsram_req, 1'b0);
        sramahb_ack = 1'b1;
        tick;
        sramahb_ack = 1'b0;
        chk1("b2b_resp2_ready", HREADYOUT, 1'b1);
        tick;
        last_addr = 20'h00013;

        // BUSY held through five sampling edges, then a late BUSY during WAIT
        BUSY = 1'b1;
        addr_phase(1'b0, 3'b010, 20'h00020);
        tick;
        bus_idle;
        chk1("busy_bw0_ready", HREADYOUT, 1'b0);
        chk1("busy_bw0_req", ahbsram_req, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk1("busy_bw_ready", HREADYOUT, 1'b0);
            chk1("busy_bw_req", ahbsram_req, 1'b0);
        end
        BUSY = 1'b0;
        tick;
        chk1("busy_req", ahbsram_req, 1'b1);
        chk1("busy_req_ready", HREADYOUT, 1'b0);
        chk("busy_req_addr", 32'(ahbsram_addr), 32'h00020);
        tick;
        BUSY = 1'b1;
        chk1("busy_wait_ready", HREADYOUT, 1'b0);
        sramahb_ack = 1'b1;
        tick;
        sramahb_ack   = 1'b0;
        BUSY          = 1'b0;
        sramahb_rdata = 32'hCAFEF00D;
        #1;
        chk1("busy_resp_ready", HREADYOUT, 1'b1);
        chk("busy_resp_hrdata", HRDATA, 32'hCAFEF00D);
        last_rdata = 32'hCAFEF00D;
        tick;
        chk("busy_hold_hrdata", HRDATA, 32'hCAFEF00D);

        // Reset asserted during WAIT; a late ack afterwards must be ignored
        addr_phase(1'b0, 3'b010, 20'h00030);
        tick;
        bus_idle;
        tick;
        chk1("mrst_wait_ready", HREADYOUT, 1'b0);
        aresetn = 1'b0;
        #1;
        chk1("mrst_ready", HREADYOUT, 1'b1);
        chk1("mrst_req", ahbsram_req, 1'b0);
        chk("mrst_addr", 32'(ahbsram_addr), 32'h0);
        chk("mrst_hrdata", HRDATA, 32'h0);
        @(negedge HCLK);
        aresetn       = 1'b1;
        sramahb_ack   = 1'b1;
        sramahb_rdata = 32'h55555555;
        tick;
        sramahb_ack = 1'b0;
        chk1("late_ack_ready", HREADYOUT, 1'b1);
        chk1("late_ack_req", ahbsram_req, 1'b0);
        chk("late_ack_hrdata", HRDATA, 32'h0);
        tick;
        chk1("late_ack_ready2", HREADYOUT, 1'b1);
        chk1("late_ack_resp2", HRESP, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahblsram_ahb_slave_if.md
# ahblsram_ahb_slave_if

AHB-Lite slave front end for the embedded-SRAM subsystem. Decodes AHB-Lite transfers from the bus matrix and drives the SRAM control interface (`ahbsram_req/write/size/addr/wdata`), which consumes it and returns `sramahb_ack/rdata`. It inserts wait states until the SRAM side completes, and holds the bus while the SRAM reports `BUSY`. It flags out-of-range and misaligned transfers with a two-cycle AHB ERROR response.

## Interface
Parameters:
- `AHB_DWIDTH`, 32: data width; only 32 is supported.
- `MEM_SIZE_BYTES`, 2048: implemented bytes. Transfers with `HADDR[19:0] >= MEM_SIZE_BYTES` get an ERROR response.

Ports:
- `HCLK`  in  1  clock
- `aresetn`  in  1  reset, asynchronous, active-low
- `HSEL`  in  1  slave select
- `HADDR`  in  20  byte address
- `HTRANS`  in  2  transfer type
- `HWRITE`  in  1  1=write
- `HSIZE`  in  3  000 byte, 001 half, 010 word
- `HBURST`  in  3  ignored; each beat is handled as a single transfer
- `HWDATA`  in  32  write data (data phase)
- `HREADYIN`  in  1  bus-level HREADY
- `HREADYOUT`  out  1  slave ready
- `HRESP`  out  1  0=OKAY, 1=ERROR
- `HRDATA`  out  32  read data
- `ahbsram_req`  out  1  one-cycle request strobe
- `ahbsram_write`  out  1  request direction
- `ahbsram_size`  out  3  registered `HSIZE`
- `ahbsram_addr`  out  20  registered `HADDR`
- `ahbsram_wdata`  out  32  equals `HWDATA` in the REQ cycle, otherwise 0
- `sramahb_ack`  in  1  completion strobe from the SRAM control block
- `sramahb_rdata`  in  32  read data; valid from the cycle after `sramahb_ack`
- `BUSY`  in  1  SRAM not ready (e.g. initialisation)

## Operation
- **Valid transfer:** sampled on an `HCLK` edge when `HSEL & HREADYIN & HTRANS[1]` and the FSM is in IDLE or RESP.
- **Address-phase capture:** `HADDR`, `HWRITE` and `HSIZE` are registered on the sampling edge.
- **Error check** at sampling:
  - `HADDR >= MEM_SIZE_BYTES`, or
  - misaligned: half with `HADDR[0]=1`, or word with `HADDR[1:0]!=0`, or
  - `HSIZE > 010`.
  - Any of these: go to ERR1. No SRAM request is issued.
- **Ignored transfers:** IDLE or BUSY `HTRANS` with `HSEL=1`, or `HSEL=0`, get a zero-wait OKAY and cause no state change.
- **FSM states:** IDLE, BWAIT, REQ, WAIT, RESP, ERR1, ERR2.
  - **IDLE:** `HREADYOUT=1`, `HRESP=0`.
    - Valid transfer with error: ERR1.
    - Valid transfer with `BUSY=1`: BWAIT.
    - Valid transfer otherwise: REQ.
  - **BWAIT:** `HREADYOUT=0`. Moves to REQ on the first cycle with `BUSY=0`.
  - **REQ:** `ahbsram_req=1` for exactly one cycle, `HREADYOUT=0`. Always moves to WAIT.
  - **WAIT:** `HREADYOUT=0`. Moves to RESP in the cycle `sramahb_ack=1`; otherwise stays in WAIT.
  - **RESP:** `HREADYOUT=1`, `HRESP=0`.
    - For a read, `HRDATA = sramahb_rdata`, and that value is held in `HRDATA` afterwards.
    - A new valid transfer sampled here follows the IDLE rules (back-to-back pipelining).
    - Otherwise go to IDLE.
  - **ERR1:** `HREADYOUT=0`, `HRESP=1`. Moves to ERR2.
  - **ERR2:** `HREADYOUT=1`, `HRESP=1`. Then IDLE; a new valid transfer sampled here follows the IDLE rules.
- **BUSY after REQ:** a `BUSY` rise after REQ does not abort the request. WAIT waits for the ack regardless.
- **Outputs outside REQ:** `ahbsram_write`, `ahbsram_size` and `ahbsram_addr` hold their registered values.
- **Reset** (any time, including mid-transfer): FSM goes to IDLE and all registers clear. The in-flight transfer is dropped.

## Timing
- **Reset values:** `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`, `ahbsram_req=0`, `ahbsram_write=0`, `ahbsram_size=0`, `ahbsram_addr=0`, `ahbsram_wdata=0`.
- **Cycle numbering:** address phase sampled at edge E0. Data-phase cycles are C1 = REQ, C2 = WAIT (ack arrives here with the companion controller), C3 = RESP.
- **Latency:** OKAY read or write takes 3 data-phase cycles (2 wait states). Each extra cycle of ack delay adds 1; each BWAIT cycle adds 1.
- **Write data:** `HWDATA` is forwarded combinationally in C1, so the controller's write enable coincides with valid data.
- **Read data:** `sramahb_rdata` is registered by the controller one edge after ack. It is therefore valid in RESP, and is muxed into `HRDATA` in that cycle.
- **ERROR response:** 2 cycles (ERR1, ERR2). `HRESP=1` in both cycles.
- **Request rate:** `ahbsram_req` is never high in two consecutive cycles. Minimum spacing is 3 cycles.

## Test plan
- **Word write:** `HADDR=0x010`, `HSIZE=010`, `HWDATA=0xDEADBEEF`, ack in C2 -> `ahbsram_req=1` in C1 with `ahbsram_addr=0x010` and `ahbsram_wdata=0xDEADBEEF`; `HREADYOUT` is 0,0,1 over C1..C3; `HRESP=0`.
- **Word read:** read `0x010`, `sramahb_rdata=0xDEADBEEF` from C3 -> `HRDATA=0xDEADBEEF` while `HREADYOUT=1` in C3.
- **Back-to-back:** byte write to `0x013` sampled in RESP of the previous transfer -> next REQ in the following cycle with `ahbsram_size=000`, `ahbsram_addr=0x013`; no idle cycle between.
- **Errors:** word read at `0x002` -> `HREADYOUT/HRESP` = 0/1 then 1/1, no `ahbsram_req`. Same result for `HADDR=0x800` with `MEM_SIZE_BYTES=2048`.
- **BUSY:** `BUSY=1` for 5 cycles at sampling -> `HREADYOUT=0` throughout, `ahbsram_req` only in the cycle after `BUSY` falls.
- **Mid-transfer reset:** `aresetn` low during WAIT -> immediately `HREADYOUT=1`, `ahbsram_req=0`; a late ack after release is ignored.
